// File: rtl/wb_mem_reader_pkg.sv
// Shared definitions for the wb_mem_reader block: register map, control/status
// bit positions and the memory-master FSM state encoding.
package wb_mem_reader_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned SEL_W  = 4;

  localparam logic [IDX_W-1:0] REG_CONTROL    = 3'd0;
  localparam logic [IDX_W-1:0] REG_STATUS     = 3'd1;
  localparam logic [IDX_W-1:0] REG_ADDRESS    = 3'd2;
  localparam logic [IDX_W-1:0] REG_COUNT      = 3'd3;
  localparam logic [IDX_W-1:0] REG_CHECKSUM   = 3'd4;
  localparam logic [IDX_W-1:0] REG_WORDS_READ = 3'd5;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_INT_EN_BIT = 1;
  localparam int unsigned CTRL_ABORT_BIT  = 2;

  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned STAT_DONE_BIT  = 1;
  localparam int unsigned STAT_ERROR_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_FIN      = 3'd4
  } state_t;

  // Field order places busy at bit 0, done at bit 1, error at bit 2.
  typedef struct packed {
    logic error;
    logic done;
    logic busy;
  } status_t;

  function automatic logic [DATA_W-1:0] status_word(input status_t s);
    return {{(DATA_W-3){1'b0}}, s};
  endfunction

endpackage

// File: rtl/wb_mem_reader_if.sv
// Bus bundle for wb_mem_reader: peripheral slave port plus memory master port.
interface wb_mem_reader_if;
  import wb_mem_reader_pkg::*;

  logic              wbs_cyc;
  logic              wbs_stb;
  logic              wbs_we;
  logic [SEL_W-1:0]  wbs_sel;
  logic [DATA_W-1:0] wbs_adr;
  logic [DATA_W-1:0] wbs_wdat;
  logic [DATA_W-1:0] wbs_rdat;
  logic              wbs_ack;
  logic              wbs_int;

  logic              mem_cyc;
  logic              mem_stb;
  logic              mem_we;
  logic [SEL_W-1:0]  mem_sel;
  logic [DATA_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdat;
  logic [DATA_W-1:0] mem_rdat;
  logic              mem_ack;
  logic              mem_int;

  modport slave (
    input  wbs_cyc, wbs_stb, wbs_we, wbs_sel, wbs_adr, wbs_wdat,
    output wbs_rdat, wbs_ack, wbs_int,
    output mem_cyc, mem_stb, mem_we, mem_sel, mem_adr, mem_wdat,
    input  mem_rdat, mem_ack, mem_int
  );

  modport master (
    output wbs_cyc, wbs_stb, wbs_we, wbs_sel, wbs_adr, wbs_wdat,
    input  wbs_rdat, wbs_ack, wbs_int,
    input  mem_cyc, mem_stb, mem_we, mem_sel, mem_adr, mem_wdat,
    output mem_rdat, mem_ack, mem_int
  );

endinterface

// File: rtl/wb_mem_reader_regs.sv
// Slave-side ack/decode and register file for wb_mem_reader; produces START and
// ABORT pulses for the memory-master FSM and accumulates the checksum.
module wb_mem_reader_regs
  import wb_mem_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc,
  input  logic              stb,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdat,
  output logic [DATA_W-1:0] rdat,
  output logic              ack,
  output logic              irq,
  input  logic              busy,
  input  logic              acc,
  input  logic [DATA_W-1:0] acc_dat,
  input  logic              set_done,
  input  logic              set_error,
  output logic              start,
  output logic              abort,
  output logic [DATA_W-1:0] base_addr,
  output logic [DATA_W-1:0] word_count
);

  logic              hold;
  logic              access;
  logic              int_en, int_en_d;
  logic              done, done_d;
  logic              error, error_d;
  logic [DATA_W-1:0] csum, csum_d;
  logic [DATA_W-1:0] words, words_d;
  logic [DATA_W-1:0] addr_d, count_d, rdat_d;
  logic              start_d, abort_d, irq_d;

  // One ack per strobe: hold blocks re-acking until the master drops stb.
  assign access = cyc & stb & ~ack & ~hold;

  always_comb begin
    int_en_d = int_en;
    done_d   = done;
    error_d  = error;
    csum_d   = csum;
    words_d  = words;
    addr_d   = base_addr;
    count_d  = word_count;
    rdat_d   = rdat;
    start_d  = 1'b0;
    abort_d  = 1'b0;

    if (acc) begin
      csum_d  = csum + acc_dat;
      words_d = words + DATA_W'(1);
    end

    if (access) begin
      if (we) begin
        case (idx)
          REG_CONTROL: begin
            int_en_d = wdat[CTRL_INT_EN_BIT];
            if (wdat[CTRL_START_BIT] && !busy) begin
              start_d = 1'b1;
              csum_d  = '0;
              words_d = '0;
              done_d  = 1'b0;
              error_d = 1'b0;
            end
            if (wdat[CTRL_ABORT_BIT] && busy) abort_d = 1'b1;
          end
          REG_ADDRESS: if (!busy) addr_d  = wdat;
          REG_COUNT:   if (!busy) count_d = wdat;
          default: ;
        endcase
      end else begin
        case (idx)
          REG_CONTROL: begin
            rdat_d = '0;
            rdat_d[CTRL_INT_EN_BIT] = int_en;
          end
          REG_STATUS: begin
            rdat_d  = status_word(status_t'({error, done, busy}));
            done_d  = 1'b0;
            error_d = 1'b0;
          end
          REG_ADDRESS:    rdat_d = base_addr;
          REG_COUNT:      rdat_d = word_count;
          REG_CHECKSUM:   rdat_d = csum;
          REG_WORDS_READ: rdat_d = words;
          default:        rdat_d = '0;
        endcase
      end
    end

    // Completion events outrank a simultaneous clear-on-read.
    if (set_done)  done_d  = 1'b1;
    if (set_error) error_d = 1'b1;

    irq_d = int_en_d & (done_d | error_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack        <= 1'b0;
      hold       <= 1'b0;
      rdat       <= '0;
      irq        <= 1'b0;
      int_en     <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      csum       <= '0;
      words      <= '0;
      base_addr  <= '0;
      word_count <= '0;
      start      <= 1'b0;
      abort      <= 1'b0;
    end else begin
      ack        <= access;
      hold       <= (ack | hold) & stb;
      rdat       <= rdat_d;
      irq        <= irq_d;
      int_en     <= int_en_d;
      done       <= done_d;
      error      <= error_d;
      csum       <= csum_d;
      words      <= words_d;
      base_addr  <= addr_d;
      word_count <= count_d;
      start      <= start_d;
      abort      <= abort_d;
    end
  end

endmodule

// File: rtl/wb_mem_reader.sv
// Wishbone peripheral that reads a programmed block of words from memory and
// sums them. Optional per-word ack timeout: define WB_MEM_READER_TIMEOUT_EN.
module wb_mem_reader
  import wb_mem_reader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic           clk,
  input logic           rst,
  wb_mem_reader_if.slave bus
);

  state_t            state, state_d;
  logic [DATA_W-1:0] work_addr, remaining;
  logic [DATA_W-1:0] base_addr, word_count;
  logic              req;
  logic              busy, start, abort;
  logic              load, advance, acc, set_done, set_error;
  logic              timeout_hit;
  logic              unused_inputs;

  assign busy = (state != ST_IDLE);

  wb_mem_reader_regs u_regs (
    .clk        (clk),
    .rst        (rst),
    .cyc        (bus.wbs_cyc),
    .stb        (bus.wbs_stb),
    .we         (bus.wbs_we),
    .idx        (bus.wbs_adr[IDX_W-1:0]),
    .wdat       (bus.wbs_wdat),
    .rdat       (bus.wbs_rdat),
    .ack        (bus.wbs_ack),
    .irq        (bus.wbs_int),
    .busy       (busy),
    .acc        (acc),
    .acc_dat    (bus.mem_rdat),
    .set_done   (set_done),
    .set_error  (set_error),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .word_count (word_count)
  );

`ifdef WB_MEM_READER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Counts consecutive cycles spent in WAIT_ACK for the current word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      tmo_cnt <= '0;
    else if (state == ST_WAIT_ACK) tmo_cnt <= tmo_cnt + TMO_W'(1);
    else                          tmo_cnt <= '0;
  end

  assign timeout_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned UNUSED_TMO_CYCLES = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    load      = 1'b0;
    advance   = 1'b0;
    acc       = 1'b0;
    set_done  = 1'b0;
    set_error = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (word_count == '0) ? ST_FIN : ST_REQ;
        end
      end
      ST_REQ: begin
        state_d = abort ? ST_IDLE : ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bus.mem_ack) begin
          acc     = 1'b1;
          state_d = ST_RELEASE;
        end else if (timeout_hit) begin
          set_error = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!bus.mem_ack) begin
          advance = 1'b1;
          state_d = (remaining == DATA_W'(1)) ? ST_FIN : ST_REQ;
        end
      end
      ST_FIN: begin
        set_done = ~abort;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      req       <= 1'b0;
      work_addr <= '0;
      remaining <= '0;
    end else begin
      state <= state_d;
      req   <= (state_d == ST_REQ) || (state_d == ST_WAIT_ACK);
      if (load) begin
        work_addr <= base_addr;
        remaining <= word_count;
      end else if (advance) begin
        work_addr <= work_addr + DATA_W'(1);
        remaining <= remaining - DATA_W'(1);
      end
    end
  end

  assign bus.mem_cyc  = req;
  assign bus.mem_stb  = req;
  assign bus.mem_we   = 1'b0;
  assign bus.mem_sel  = {SEL_W{1'b1}};
  assign bus.mem_adr  = work_addr;
  assign bus.mem_wdat = '0;

  assign unused_inputs = &{1'b0, bus.wbs_sel, bus.wbs_adr[DATA_W-1:IDX_W], bus.mem_int};

endmodule

// File: tb/tb_wb_mem_reader.sv
// Self-checking bench for wb_mem_reader: register table, directed block reads,
// randomized blocks against a summing model, abort, timeout and reset cases.
module tb_wb_mem_reader;
  import wb_mem_reader_pkg::*;

  localparam int unsigned TMO = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_mem_reader_if bus();

  wb_mem_reader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc_num = 0;
  always @(posedge clk) cyc_num = cyc_num + 1;

  // Zero-wait memory: acks the cycle after it sees a request, stops at ack_stop_at.
  logic [31:0] mem [256];
  int mem_acks    = 0;
  int cyc_hi      = 0;
  int ack_stop_at = 32'h7fffffff;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_ack  <= 1'b0;
      bus.mem_rdat <= '0;
    end else begin
      if (bus.mem_cyc) cyc_hi <= cyc_hi + 1;
      if (bus.mem_cyc && bus.mem_stb && !bus.mem_ack && mem_acks < ack_stop_at) begin
        bus.mem_ack  <= 1'b1;
        bus.mem_rdat <= mem[bus.mem_adr[7:0]];
        mem_acks     <= mem_acks + 1;
      end else begin
        bus.mem_ack <= 1'b0;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int last_ack_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input bit we, input logic [2:0] idx, input logic [31:0] wd,
                         output logic [31:0] rd);
    bit got = 1'b0;
    rd = '0;
    @(negedge clk);
    bus.wbs_cyc  = 1'b1;
    bus.wbs_stb  = 1'b1;
    bus.wbs_we   = we;
    bus.wbs_adr  = {29'b0, idx};
    bus.wbs_wdat = wd;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack) begin
        got          = 1'b1;
        last_ack_cyc = cyc_num;
        rd           = bus.wbs_rdat;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wb_ack_timeout: got no ack for idx %0d expected ack within 16 cycles", idx);
    end
    @(negedge clk);
    bus.wbs_cyc = 1'b0;
    bus.wbs_stb = 1'b0;
    bus.wbs_we  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, idx, d, dummy);
  endtask

  task automatic rd(input logic [2:0] idx, output logic [31:0] d);
    wb_xfer(1'b0, idx, '0, d);
  endtask

  // Program a block, START with INT_EN, return cycles from START ack to interrupt.
  task automatic run_block(input logic [31:0] a, input logic [31:0] n, output int lat);
    int start_cyc;
    wr(REG_ADDRESS, a);
    wr(REG_COUNT, n);
    wr(REG_CONTROL, 32'h3);
    start_cyc = last_ack_cyc;
    lat = -1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_int) begin
        lat = cyc_num - start_cyc;
        break;
      end
    end
  endtask

  function automatic logic [31:0] model_sum(input logic [31:0] a, input int n);
    logic [31:0] s = '0;
    for (int k = 0; k < n; k++) s = s + mem[8'(a + 32'(k))];
    return s;
  endfunction

  typedef struct {
    bit          we;
    logic [2:0]  idx;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [31:0] r;
    int lat, base, cbase, n;
    logic [31:0] a, exp_sum;

    bus.wbs_cyc  = 1'b0;
    bus.wbs_stb  = 1'b0;
    bus.wbs_we   = 1'b0;
    bus.wbs_sel  = 4'hF;
    bus.wbs_adr  = '0;
    bus.wbs_wdat = '0;
    bus.mem_int  = 1'b0;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[16] = 32'd1; mem[17] = 32'd2; mem[18] = 32'd3; mem[19] = 32'd4;
    mem[32] = 32'hFFFF_FFFF; mem[33] = 32'h0000_0002;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_cyc_stb", {30'b0, bus.mem_cyc, bus.mem_stb}, 32'h0);
    chk("rst_mem_sel", {28'b0, bus.mem_sel}, 32'hF);
    chk("rst_mem_we_adr", bus.mem_adr | {31'b0, bus.mem_we}, 32'h0);
    chk("rst_wbs_ack_int", {30'b0, bus.wbs_ack, bus.wbs_int}, 32'h0);
    chk("rst_wbs_rdat", bus.wbs_rdat, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    tbl[0]  = '{1'b0, REG_CONTROL,    32'h0,         32'h0};
    tbl[1]  = '{1'b0, REG_STATUS,     32'h0,         32'h0};
    tbl[2]  = '{1'b0, REG_ADDRESS,    32'h0,         32'h0};
    tbl[3]  = '{1'b0, REG_COUNT,      32'h0,         32'h0};
    tbl[4]  = '{1'b0, REG_CHECKSUM,   32'h0,         32'h0};
    tbl[5]  = '{1'b0, REG_WORDS_READ, 32'h0,         32'h0};
    tbl[6]  = '{1'b1, REG_ADDRESS,    32'h1234_5678, 32'h0};
    tbl[7]  = '{1'b0, REG_ADDRESS,    32'h0,         32'h1234_5678};
    tbl[8]  = '{1'b1, REG_COUNT,      32'h0000_ABCD, 32'h0};
    tbl[9]  = '{1'b0, REG_COUNT,      32'h0,         32'h0000_ABCD};
    tbl[10] = '{1'b1, REG_CONTROL,    32'hFFFF_FFFA, 32'h0};
    tbl[11] = '{1'b0, REG_CONTROL,    32'h0,         32'h2};
    tbl[12] = '{1'b1, REG_CONTROL,    32'h0,         32'h0};
    tbl[13] = '{1'b0, REG_CONTROL,    32'h0,         32'h0};
    tbl[14] = '{1'b1, 3'd6,           32'hDEAD_BEEF, 32'h0};
    tbl[15] = '{1'b0, 3'd7,           32'h0,         32'h0};

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].we) wr(tbl[i].idx, tbl[i].wdat);
      else begin
        rd(tbl[i].idx, r);
        chk($sformatf("table_%0d", i), r, tbl[i].exp);
      end
    end
    rd(3'd6, r);
    chk("reg6_zero", r, 32'h0);

    // Four words 1..4 at 0x10.
    base = mem_acks;
    run_block(32'h10, 32'd4, lat);
    chk("blk4_latency", 32'(lat), 32'd14);
    rd(REG_STATUS, r);     chk("blk4_status", r, 32'h2);
    rd(REG_CHECKSUM, r);   chk("blk4_checksum", r, 32'd10);
    rd(REG_WORDS_READ, r); chk("blk4_words", r, 32'd4);
    chk("blk4_mem_acks", 32'(mem_acks - base), 32'd4);

    // Checksum wraps modulo 2^32.
    run_block(32'h20, 32'd2, lat);
    rd(REG_CHECKSUM, r);   chk("wrap_checksum", r, 32'h1);
    rd(REG_STATUS, r);     chk("wrap_status", r, 32'h2);

    // COUNT=0 completes without any memory cycle.
    cbase = cyc_hi;
    run_block(32'h30, 32'd0, lat);
    chk("cnt0_latency", 32'(lat), 32'd2);
    rd(REG_STATUS, r);     chk("cnt0_status", r, 32'h2);
    chk("cnt0_int_cleared", {31'b0, bus.wbs_int}, 32'h0);
    chk("cnt0_no_mem_cyc", 32'(cyc_hi - cbase), 32'h0);

    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(0, 20));
      a = 32'($urandom_range(0, 230));
      for (int k = 0; k < n; k++) mem[8'(a + 32'(k))] = $urandom;
      exp_sum = model_sum(a, n);
      base = mem_acks;
      run_block(a, 32'(n), lat);
      chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'(3 * n + 2));
      rd(REG_CHECKSUM, r);   chk($sformatf("rnd%0d_checksum", t), r, exp_sum);
      rd(REG_WORDS_READ, r); chk($sformatf("rnd%0d_words", t), r, 32'(n));
      rd(REG_STATUS, r);     chk($sformatf("rnd%0d_status", t), r, 32'h2);
      chk($sformatf("rnd%0d_mem_acks", t), 32'(mem_acks - base), 32'(n));
    end

    // Abort a 100-word block with memory stalled after 10 words.
    base = mem_acks;
    ack_stop_at = base + 10;
    wr(REG_ADDRESS, 32'h40);
    wr(REG_COUNT, 32'd100);
    wr(REG_CONTROL, 32'h3);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (mem_acks - base >= 10) break;
    end
    chk("abort_acks_before", 32'(mem_acks - base), 32'd10);
    repeat (4) @(posedge clk);
    wr(REG_ADDRESS, 32'h99);
    wr(REG_CONTROL, 32'h3);
    rd(REG_WORDS_READ, r); chk("busy_start_ignored", r, 32'd10);
    rd(REG_STATUS, r);     chk("busy_status", r, 32'h1);
    rd(REG_ADDRESS, r);    chk("busy_addr_write_ignored", r, 32'h40);
    wr(REG_CONTROL, 32'h6);
    @(posedge clk); #1;
    chk("abort_cyc_dropped", {30'b0, bus.mem_cyc, bus.mem_stb}, 32'h0);
    rd(REG_STATUS, r);     chk("abort_status", r, 32'h0);
    rd(REG_WORDS_READ, r); chk("abort_words", r, 32'd10);
    rd(REG_CHECKSUM, r);   chk("abort_checksum", r, model_sum(32'h40, 10));
    chk("abort_int_low", {31'b0, bus.wbs_int}, 32'h0);
    ack_stop_at = 32'h7fffffff;

`ifdef WB_MEM_READER_TIMEOUT_EN
    ack_stop_at = mem_acks;
    run_block(32'h50, 32'd3, lat);
    chk("tmo_latency", 32'(lat), 32'(TMO + 2));
    chk("tmo_cyc_dropped", {30'b0, bus.mem_cyc, bus.mem_stb}, 32'h0);
    rd(REG_STATUS, r);     chk("tmo_status", r, 32'h4);
    rd(REG_WORDS_READ, r); chk("tmo_words", r, 32'd0);
    ack_stop_at = 32'h7fffffff;
`endif

    // Reset in the middle of a transfer.
    wr(REG_ADDRESS, 32'h60);
    wr(REG_COUNT, 32'd50);
    wr(REG_CONTROL, 32'h3);
    repeat (6) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.mem_cyc) break;
    end
    chk("pre_rst_cyc_high", {31'b0, bus.mem_cyc}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_cyc_stb", {30'b0, bus.mem_cyc, bus.mem_stb}, 32'h0);
    chk("midrst_mem_adr", bus.mem_adr, 32'h0);
    chk("midrst_mem_sel", {28'b0, bus.mem_sel}, 32'hF);
    chk("midrst_wbs_ack_int", {30'b0, bus.wbs_ack, bus.wbs_int}, 32'h0);
    chk("midrst_wbs_rdat", bus.wbs_rdat, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd(REG_STATUS, r);     chk("postrst_status", r, 32'h0);
    rd(REG_CHECKSUM, r);   chk("postrst_checksum", r, 32'h0);
    rd(REG_COUNT, r);      chk("postrst_count", r, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
